// File: rtl/lsu.sv
// Load/store unit between the core and a single-port, combinational-read data memory.
// Aligned accesses pass straight through, in-word halves are merged, word-crossing accesses split.
module lsu #(
  parameter bit MISALIGN_TRAP = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic        sign_i,
  input  logic [1:0]  mask_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        stall_o,
  output logic [31:0] rd_o,
  output logic        trap_o,
  output logic [15:0] split_cnt_o,
  output logic        dram_we_o,
  output logic        sign_o,
  output logic [1:0]  mask_op_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] rd_i
);

  typedef enum logic {ST_IDLE = 1'b0, ST_SECOND = 1'b1} state_t;

  state_t      r_state;
  logic        r_we;
  logic        r_sign;
  logic        r_word;
  logic [1:0]  r_off;
  logic [29:0] r_word_addr;
  logic [31:0] r_data;
  logic [31:0] r_buf;
  logic [15:0] r_cnt;

  logic        w_trap_mode;
  logic [1:0]  w_off;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_aligned;
  logic        w_inword;
  logic        w_cross;
  logic        w_start;
  logic [4:0]  w_sh_first;
  logic [31:0] w_lo_mask;
  logic [31:0] w_first_data;
  logic [31:0] w_inword_data;
  logic [31:0] w_inword_rd;
  logic [1:0]  w_inv;
  logic [1:0]  w_rem;
  logic [4:0]  w_sh_inv;
  logic [4:0]  w_sh_rem;
  logic [31:0] w_join;
  logic [31:0] w_sec_rd;
  logic [31:0] w_rem_mask;
  logic [31:0] w_sec_data;

  assign w_trap_mode = MISALIGN_TRAP;
  assign w_off       = addr_i[1:0];
  assign w_is_half   = (mask_op_i == 2'b01);
  assign w_is_word   = mask_op_i[1];
  assign w_aligned   = (mask_op_i == 2'b00) | (w_is_half & ~addr_i[0]) |
                       (w_is_word & (w_off == 2'b00));
  assign w_inword    = w_is_half & (w_off == 2'b01);
  assign w_cross     = ~w_aligned & ~w_inword;
  assign w_start     = (r_state == ST_IDLE) & req_i & w_cross & ~w_trap_mode;

  assign w_sh_first    = {w_off, 3'b000};
  assign w_lo_mask     = (32'h1 << w_sh_first) - 32'h1;
  assign w_first_data  = (rd_i & w_lo_mask) | (data_i << w_sh_first);
  assign w_inword_data = {rd_i[31:24], data_i[15:0], rd_i[7:0]};
  assign w_inword_rd   = {{16{sign_i & rd_i[23]}}, rd_i[23:8]};

  // Word A took 4-o bytes; the remaining n-(4-o) bytes land in the low end of word B.
  assign w_inv      = 2'b00 - r_off;
  assign w_rem      = r_word ? r_off : 2'b01;
  assign w_sh_inv   = {w_inv, 3'b000};
  assign w_sh_rem   = {w_rem, 3'b000};
  assign w_join     = (rd_i << w_sh_inv) | r_buf;
  assign w_sec_rd   = r_word ? w_join : {{16{r_sign & w_join[15]}}, w_join[15:0]};
  assign w_rem_mask = (32'h1 << w_sh_rem) - 32'h1;
  assign w_sec_data = (rd_i & ~w_rem_mask) | ((r_data >> w_sh_inv) & w_rem_mask);

  // NOTE: every output gets a default first, so no path through this block can infer a latch.
  always_comb begin
    addr_o    = addr_i;
    mask_op_o = mask_op_i;
    data_o    = data_i;
    sign_o    = 1'b0;
    dram_we_o = 1'b0;
    rd_o      = rd_i;
    stall_o   = 1'b0;
    trap_o    = 1'b0;
    // NOTE: strobes are gated by rst_i so a request held during reset never writes or stalls.
    if (r_state == ST_SECOND) begin
      addr_o    = {r_word_addr + 30'd1, 2'b00};
      mask_op_o = 2'b10;
      data_o    = w_sec_data;
      dram_we_o = r_we & ~rst_i;
      rd_o      = w_sec_rd;
    end else if (w_trap_mode && !w_aligned) begin
      trap_o = req_i & ~rst_i;
      rd_o   = 32'h0;
    end else if (w_aligned) begin
      sign_o    = sign_i;
      dram_we_o = req_i & we_i & ~rst_i;
    end else if (w_inword) begin
      addr_o    = {addr_i[31:2], 2'b00};
      mask_op_o = 2'b10;
      data_o    = w_inword_data;
      dram_we_o = req_i & we_i & ~rst_i;
      rd_o      = w_inword_rd;
    end else begin
      addr_o    = {addr_i[31:2], 2'b00};
      mask_op_o = 2'b10;
      data_o    = w_first_data;
      dram_we_o = req_i & we_i & ~rst_i;
      rd_o      = 32'h0;
      stall_o   = req_i & ~rst_i;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_sign      <= 1'b0;
      r_word      <= 1'b0;
      r_off       <= 2'b00;
      r_word_addr <= 30'h0;
      r_data      <= 32'h0;
      r_buf       <= 32'h0;
      r_cnt       <= 16'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_SECOND;
            r_we        <= we_i;
            r_sign      <= sign_i;
            r_word      <= mask_op_i[1];
            r_off       <= w_off;
            r_word_addr <= addr_i[31:2];
            r_data      <= data_i;
            r_buf       <= rd_i >> w_sh_first;
          end
        end
        ST_SECOND: begin
          r_state <= ST_IDLE;
          if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'h1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign split_cnt_o = r_cnt;

endmodule
